// File: rtl/tff_ctrl_pkg.sv
// tff_ctrl_pkg: opcode and controller state encodings shared by the T-flip-flop counter controller.
package tff_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_CLEAR = 2'b00,
        OP_LOAD  = 2'b01,
        OP_UP    = 2'b10,
        OP_DOWN  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/tff_cell.sv
// tff_cell: one T flip-flop with asynchronous active-high reset to 0.
module tff_cell (
    input  logic clk,
    input  logic rst,
    input  logic t_i,
    output logic q_o,
    output logic q_bar_o
);
    logic q_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            q_q <= 1'b0;
        else
            q_q <= q_q ^ t_i;
    end

    assign q_o     = q_q;
    assign q_bar_o = ~q_q;
endmodule

// File: rtl/tff_count_ctrl.sv
// tff_count_ctrl: command-driven clear/load/up/down sequencer over a bank of T flip-flops.
// Define TFF_CTRL_SAT_EN to hold at the count limits instead of wrapping.
module tff_count_ctrl
    import tff_ctrl_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [WIDTH-1:0] cmd_steps,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_bar,
    output logic             done,
    output logic             tc
);
    state_e           state_q, state_d;
    op_e              op_q;
    logic [WIDTH-1:0] data_q, rem_q, rem_d, up_t, dn_t, t;
    logic             tc_q, accept, exec, step, boundary, last, hold;

    assign cmd_ready = state_q == ST_IDLE && !rst;
    assign accept    = cmd_valid && cmd_ready;
    assign exec      = state_q == ST_EXEC;
    // a zero-step UP/DOWN still spends one EXEC cycle, but issues no toggles
    assign step      = (op_q == OP_UP || op_q == OP_DOWN) && rem_q != '0;
    assign boundary  = exec && step && (op_q == OP_UP ? &q : ~|q);
    assign last      = op_q == OP_CLEAR || op_q == OP_LOAD || rem_q <= WIDTH'(1);

`ifdef TFF_CTRL_SAT_EN
    assign hold = boundary;
`else
    assign hold = 1'b0;
`endif

    assign up_t[0] = 1'b1;
    assign dn_t[0] = 1'b1;
    for (genvar i = 1; i < WIDTH; i++) begin : g_carry
        assign up_t[i] = &q[i-1:0];
        assign dn_t[i] = ~|q[i-1:0];
    end

    assign t = !exec || hold   ? '0 :
               op_q == OP_CLEAR ? q :
               op_q == OP_LOAD  ? q ^ data_q :
               !step            ? '0 :
               op_q == OP_UP    ? up_t : dn_t;

    assign state_d = accept ? ST_EXEC : exec ? (last ? ST_DONE : ST_EXEC) : ST_IDLE;
    assign rem_d   = accept ? cmd_steps : step && exec ? rem_q - WIDTH'(1) : rem_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            op_q    <= OP_CLEAR;
            data_q  <= '0;
            rem_q   <= '0;
            tc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            tc_q    <= boundary;
            if (accept) begin
                op_q   <= op_e'(cmd_op);
                data_q <= cmd_data;
            end
        end
    end

    assign done = state_q == ST_DONE;
    assign tc   = tc_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        tff_cell u_cell (
            .clk    (clk),
            .rst    (rst),
            .t_i    (t[i]),
            .q_o    (q[i]),
            .q_bar_o(q_bar[i])
        );
    end
endmodule
